memory_responder: RTL and testbench

Memory-side endpoint of the processor's instruction-fetch and data-access ports. It accepts the fetch address and the data address, write data and write enable that the pipeline drives. It returns the instruction word and the load data from a shared dual-port word array. A power-up clear sequencer and an out-of-range detector are included. It sits outside the pipeline core at top level and closes the loop on DataIn/DataIn_Mem.

---
 rtl/processor_pkg.sv | 18 +
 rtl/dual_port_ram.sv | 40 ++++
 rtl/memory_responder.sv | 144 ++++++++++++++
 tb/tb_memory_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// ---------------------------------------------------------------------------
// processor_pkg
// Shared definitions for the processor's memory-side blocks.
//   WORD_W      : width of an instruction / data word (20 bits)
//   NOP_WORD    : value returned for reads that hit no real storage
//   memState_t  : sequencer states of memory_responder (CLEAR, READY)
// ---------------------------------------------------------------------------
package processor_pkg;

    localparam int WORD_W = 20;
    localparam logic [WORD_W-1:0] NOP_WORD = 20'h00000;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } memState_t;

endpackage

// File: rtl/dual_port_ram.sv
// ---------------------------------------------------------------------------
// dual_port_ram
// Storage-only word array shared by instruction fetch and data access.
// No reset: contents are undefined until written.
// Ports:
//   clk    in   write clock
//   addrI  in   port I read index (read-only port)
//   rdataI out  port I read data (combinational)
//   addrD  in   port D read/write index
//   weD    in   port D write strobe
//   wdataD in   port D write data
//   rdataD out  port D read data; write-first, so a write shows its own data
// ---------------------------------------------------------------------------
module dual_port_ram
    import processor_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addrI,
    output logic [WORD_W-1:0] rdataI,
    input  logic [ADDR_W-1:0] addrD,
    input  logic              weD,
    input  logic [WORD_W-1:0] wdataD,
    output logic [WORD_W-1:0] rdataD
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (weD) begin
            mem[addrD] <= wdataD;
        end
    end

    assign rdataI = mem[addrI];
    assign rdataD = weD ? wdataD : mem[addrD];

endmodule

// File: rtl/memory_responder.sv
// ---------------------------------------------------------------------------
// memory_responder
// Memory-side endpoint of the instruction-fetch and data-access ports.
// Optional feature macro: MEM_CLEAR_EN -- when defined, a power-up sequencer
// zeroes every word after reset (Busy high meanwhile); when undefined the
// block is READY straight out of reset and Busy is tied low.
// Ports:
//   Clock               in   rising-edge clock
//   Reset               in   asynchronous active-low reset
//   Daddress            in   instruction fetch word address
//   DataIn              out  fetched instruction word (registered)
//   MEM_Address_Out     in   data access word address
//   MEM_WriteData_Out   in   store data
//   MEM_WriteEnable_Out in   store strobe
//   DataIn_Mem          out  load data (registered)
//   Busy                out  clear sequence running; core must stay in reset
//   OutOfRange          out  sticky: some access addressed a word >= DEPTH
// ---------------------------------------------------------------------------
module memory_responder
    import processor_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [WORD_W-1:0] Daddress,
    output logic [WORD_W-1:0] DataIn,
    input  logic [WORD_W-1:0] MEM_Address_Out,
    input  logic [WORD_W-1:0] MEM_WriteData_Out,
    input  logic              MEM_WriteEnable_Out,
    output logic [WORD_W-1:0] DataIn_Mem,
    output logic              Busy,
    output logic              OutOfRange
);

    logic [ADDR_W-1:0] idxI;
    logic [ADDR_W-1:0] idxD;
    logic              oorI;
    logic              oorD;
    logic              clearing;
    logic [ADDR_W-1:0] ramAddrD;
    logic              ramWe;
    logic [WORD_W-1:0] ramWdata;
    logic [WORD_W-1:0] ramRdI;
    logic [WORD_W-1:0] ramRdD;
    logic              bypassI;
    logic [WORD_W-1:0] instNext_p0;
    logic [WORD_W-1:0] loadNext_p0;
    logic              oorSet_p0;

    assign idxI = Daddress[ADDR_W-1:0];
    assign idxD = MEM_Address_Out[ADDR_W-1:0];
    // Any set bit above the index field points past the array.
    assign oorI = |(Daddress >> ADDR_W);
    assign oorD = |(MEM_Address_Out >> ADDR_W);

`ifdef MEM_CLEAR_EN
    memState_t         state;
    logic [ADDR_W-1:0] clearCnt;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= CLEAR;
            clearCnt <= '0;
            Busy     <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (clearCnt == ADDR_W'(DEPTH - 1)) begin
                        state <= READY;
                        Busy  <= 1'b0;
                    end else begin
                        clearCnt <= clearCnt + 1'b1;
                    end
                end
                default: begin
                    state <= READY;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clearing = (state == CLEAR);
    assign ramAddrD = clearing ? clearCnt : idxD;
`else
    assign Busy     = 1'b0;
    assign clearing = 1'b0;
    assign ramAddrD = idxD;
`endif

    // While clearing, port D is owned by the sequencer and the core's
    // inputs are ignored. Out-of-range stores never reach the array.
    assign ramWe    = clearing | (MEM_WriteEnable_Out & ~oorD);
    assign ramWdata = clearing ? NOP_WORD : MEM_WriteData_Out;

    dual_port_ram #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) uRam (
        .clk   (Clock),
        .addrI (idxI),
        .rdataI(ramRdI),
        .addrD (ramAddrD),
        .weD   (ramWe),
        .wdataD(ramWdata),
        .rdataD(ramRdD)
    );

    // Fetch of the word being stored this cycle sees the new data.
    assign bypassI = ~clearing & ramWe & ~oorI & (idxI == idxD);

    always_comb begin
        instNext_p0 = ramRdI;
        loadNext_p0 = ramRdD;
        if (clearing || oorI) begin
            instNext_p0 = NOP_WORD;
        end else if (bypassI) begin
            instNext_p0 = MEM_WriteData_Out;
        end
        if (clearing || oorD) begin
            loadNext_p0 = NOP_WORD;
        end
    end

    assign oorSet_p0 = ~clearing & (oorI | oorD);

    // ---- output register stage ----
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            DataIn     <= NOP_WORD;
            DataIn_Mem <= NOP_WORD;
            OutOfRange <= 1'b0;
        end else begin
            DataIn     <= instNext_p0;
            DataIn_Mem <= loadNext_p0;
            if (oorSet_p0) begin
                OutOfRange <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;
    import processor_pkg::*;

    localparam int DEPTH = 16;
    localparam int ADDR_W = 4;

    logic              Clock = 1'b0;
    logic              Reset;
    logic [WORD_W-1:0] Daddress;
    logic [WORD_W-1:0] DataIn;
    logic [WORD_W-1:0] MEM_Address_Out;
    logic [WORD_W-1:0] MEM_WriteData_Out;
    logic              MEM_WriteEnable_Out;
    logic [WORD_W-1:0] DataIn_Mem;
    logic              Busy;
    logic              OutOfRange;

    memory_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .Daddress           (Daddress),
        .DataIn             (DataIn),
        .MEM_Address_Out    (MEM_Address_Out),
        .MEM_WriteData_Out  (MEM_WriteData_Out),
        .MEM_WriteEnable_Out(MEM_WriteEnable_Out),
        .DataIn_Mem         (DataIn_Mem),
        .Busy               (Busy),
        .OutOfRange         (OutOfRange)
    );

    always #5 Clock = ~Clock;

`ifdef MEM_CLEAR_EN
    localparam bit CLEAR_BUILD = 1'b1;
`else
    localparam bit CLEAR_BUILD = 1'b0;
`endif

    typedef struct {
        logic [WORD_W-1:0] expI;
        bit                knI;
        logic [WORD_W-1:0] expD;
        bit                knD;
        bit                expOor;
    } exp_t;

    exp_t              sbq[$];
    logic [WORD_W-1:0] model[DEPTH];
    bit                known[DEPTH];
    bit                oorModel;
    int                assertCount = 0;
    int                failCount = 0;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic driveIdle();
        Daddress            = '0;
        MEM_Address_Out     = '0;
        MEM_WriteData_Out   = '0;
        MEM_WriteEnable_Out = 1'b0;
    endtask

    task automatic modelReset();
        oorModel = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = '0;
            known[i] = CLEAR_BUILD;
        end
    endtask

    // One READY-state cycle: drive, predict, then compare after the edge.
    task automatic doCycle(input string tag, input logic [19:0] aI, input logic [19:0] aD,
                           input logic weIn, input logic [19:0] wd);
        exp_t e;
        bit   oI;
        bit   oD;
        @(negedge Clock);
        Daddress            = aI;
        MEM_Address_Out     = aD;
        MEM_WriteEnable_Out = weIn;
        MEM_WriteData_Out   = wd;
        oI = (aI >= DEPTH);
        oD = (aD >= DEPTH);
        if (weIn && !oD) begin
            model[aD[3:0]] = wd;
            known[aD[3:0]] = 1'b1;
        end
        e.expI   = oI ? 20'h0 : model[aI[3:0]];
        e.knI    = oI ? 1'b1 : known[aI[3:0]];
        e.expD   = oD ? 20'h0 : model[aD[3:0]];
        e.knD    = oD ? 1'b1 : known[aD[3:0]];
        oorModel = oorModel | oI | oD;
        e.expOor = oorModel;
        sbq.push_back(e);
        @(posedge Clock);
        #1;
        e = sbq.pop_front();
        if (e.knI) checkEq({tag, ".DataIn"}, 32'(DataIn), 32'(e.expI));
        if (e.knD) checkEq({tag, ".DataIn_Mem"}, 32'(DataIn_Mem), 32'(e.expD));
        checkEq({tag, ".OutOfRange"}, 32'(OutOfRange), 32'(e.expOor));
        checkEq({tag, ".Busy"}, 32'(Busy), 32'd0);
    endtask

    // Counts cycles with Busy high after reset release; bounded.
    task automatic countBusy(input string tag, input int expCycles);
        int n;
        n = 0;
        while (n < 100) begin
            @(posedge Clock);
            #1;
            n++;
            if (n == 1) begin
                checkEq({tag, ".DataIn_clear"}, 32'(DataIn), 32'd0);
                checkEq({tag, ".DataIn_Mem_clear"}, 32'(DataIn_Mem), 32'd0);
            end
            if (!Busy) break;
        end
        checkEq({tag, ".busyCycles"}, n, expCycles);
    endtask

    initial begin
        Reset = 1'b0;
        driveIdle();
        modelReset();
        repeat (2) @(posedge Clock);
        #1;
        checkEq("reset.DataIn", 32'(DataIn), 32'd0);
        checkEq("reset.DataIn_Mem", 32'(DataIn_Mem), 32'd0);
        checkEq("reset.OutOfRange", 32'(OutOfRange), 32'd0);
        checkEq("reset.Busy", 32'(Busy), 32'(CLEAR_BUILD));

        @(negedge Clock);
        Reset = 1'b1;
        if (CLEAR_BUILD) begin
            // A store attempted during the clear must be ignored.
            MEM_Address_Out     = 20'd2;
            MEM_WriteData_Out   = 20'h55555;
            MEM_WriteEnable_Out = 1'b1;
            countBusy("clear1", DEPTH);
            driveIdle();

            // Reset at counter 9 restarts the full clear.
            @(negedge Clock);
            Reset = 1'b0;
            #1;
            @(negedge Clock);
            Reset = 1'b1;
            repeat (9) @(posedge Clock);
            #2;
            Reset = 1'b0;
            #1;
            checkEq("midclear.Busy", 32'(Busy), 32'd1);
            @(negedge Clock);
            Reset = 1'b1;
            countBusy("clear2", DEPTH);
        end else begin
            @(posedge Clock);
            #1;
            checkEq("noclear.Busy", 32'(Busy), 32'd0);
        end

        // Sweep every word on both ports.
        for (int i = 0; i < DEPTH; i++) begin
            doCycle("sweep", 20'(i), 20'(DEPTH - 1 - i), 1'b0, 20'h0);
        end

        doCycle("store5", 20'd0, 20'd5, 1'b1, 20'hABCDE);
        doCycle("read5", 20'd5, 20'd5, 1'b0, 20'h0);
        doCycle("bypass7", 20'd7, 20'd7, 1'b1, 20'h12345);
        doCycle("read7", 20'd7, 20'd15, 1'b0, 20'h0);

        doCycle("b2b1", 20'd0, 20'd3, 1'b1, 20'h00001);
        doCycle("b2b2", 20'd0, 20'd3, 1'b1, 20'h00002);
        doCycle("b2b3", 20'd0, 20'd3, 1'b1, 20'h00003);
        doCycle("b2bread", 20'd3, 20'd3, 1'b0, 20'h0);

        doCycle("inRange15", 20'd15, 20'd15, 1'b0, 20'h0);
        doCycle("store0", 20'd1, 20'd0, 1'b1, 20'h11111);
        doCycle("oorRead", 20'd0, 20'h00400, 1'b0, 20'h0);
        doCycle("oorWrite", 20'd1, 20'h00400, 1'b1, 20'h77777);
        doCycle("oorEdge", 20'h00010, 20'h00010, 1'b1, 20'h22222);
        doCycle("word0kept", 20'd0, 20'd0, 1'b0, 20'h0);

        for (int k = 0; k < 40; k++) begin
            doCycle("rand", 20'($urandom_range(0, DEPTH - 1)), 20'($urandom_range(0, DEPTH - 1)),
                    1'($urandom_range(0, 1)), 20'($urandom));
        end

        @(negedge Clock);
        Reset = 1'b0;
        #1;
        checkEq("reset2.OutOfRange", 32'(OutOfRange), 32'd0);
        checkEq("reset2.DataIn", 32'(DataIn), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
